lsq_alloc_sched: RTL and testbench
==================================

// Module: lsq_alloc_sched
// PURPOSE
//  Allocation controller and memory-issue scheduler for the load/store queue (LSQ).
//  - Takes the compacted load/store ROB-index groups from the dispatch reorder stage.
//  - Allocates them into circular load (LQ) and store (SQ) queues, stalling dispatch when space is short.
//  - Issues entries to the single memory port, oldest first, and frees entries on commit.
// PARAMETERS
//  LQ_DEPTH  16  load queue entries, power of 2, >= 4
//  SQ_DEPTH  16  store queue entries, power of 2, >= 4
//  IDX_W     7   ROB index width
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  ld_indx_in     in   32  4 x {valid, idx[6:0]}; byte 0 is the oldest; valid bytes are contiguous from byte 0
//  st_indx_in     in   32  same layout, stores
//  disp_valid     in   1   dispatch group present this cycle
//  disp_stall     out  1   group not accepted; upstream holds it
//  ld_cmt_cnt     in   3   oldest loads retired this cycle (0-4)
//  st_cmt_cnt     in   3   oldest stores retired this cycle (0-4)
//  rob_head       in   7   current ROB head index, reference point for age
//  flush          in   1   mispredict/exception: discard all entries
//  mem_req_valid  out  1   issue request to the memory port
//  mem_req_is_st  out  1   1 = store, 0 = load
//  mem_req_indx   out  7   ROB index of the issued entry
//  mem_req_ready  in   1   memory port accepts the request
//  lq_count       out  $clog2(LQ_DEPTH)+1   occupied LQ entries
//  sq_count       out  $clog2(SQ_DEPTH)+1   occupied SQ entries
// BEHAVIOUR
//  - Reset (async): all pointers and counts = 0; disp_stall = 0; mem_req_valid = 0; mem_req_* = 0.
//  - Queue state: each queue keeps head (commit), iss (next to issue), tail (alloc) pointers.
//    Pointers wrap mod DEPTH.
//  - Group size: nld/nst = number of set bit7 flags, 0-4. A non-contiguous valid pattern is illegal (assert).
//  - Accept rule: accept = disp_valid && !flush && (LQ_DEPTH-lq_count >= nld) && (SQ_DEPTH-sq_count >= nst).
//    - Free space uses the registered counts; same-cycle commits do not count.
//    - disp_stall = disp_valid && !accept, combinational.
//  - Allocation: on accept, the valid bytes are written in order at tail..tail+n-1 and tail += n.
//    An all-invalid group is accepted with no effect.
//  - Commit: head += cnt.
//    - cnt greater than the issued-but-uncommitted entries (iss-head) is illegal (assert).
//    - count_next = count + alloc - cnt.
//  - Issue candidates: LQ[iss] if iss != tail; likewise SQ.
//    - If only one candidate exists, it is selected.
//    - If both exist, select the one with the smaller (indx - rob_head) mod 128, i.e. the older.
//    - Outputs are combinational from registered state and stable while ready = 0,
//      because allocation only moves tail.
//    - On mem_req_valid && mem_req_ready the selected iss pointer advances by 1.
//  - Simultaneous events: alloc, commit and issue in one cycle are all applied.
//    A full queue with a commit in the same cycle still stalls that cycle.
//  - Flush: highest priority. Next edge sets all pointers and counts to 0.
//    During the flush cycle disp_stall = disp_valid and mem_req_valid = 0.
//  - Wrap: indices wrap mod 128 in the age compare; queue pointers wrap mod DEPTH.
// CONFIGURATION
//  - LSQ_PERF_CNT_EN defined: adds output disp_stall_cnt[15:0].
//    - Counts cycles with disp_stall = 1, saturating at 16'hFFFF.
//    - Cleared by reset only; flush does not clear it.
//  - Undefined: no port, no counter logic.
// STRUCTURE
//  - Package lsq_pkg:
//    - IDX_W and SLOTS = 4.
//    - lsq_slot_t {valid, idx} byte typedef.
//    - popcount4 function.
//    - age_older(a, b, head) function.
//  - Sub-module lsq_ring_ctrl, instantiated once for the LQ and once for the SQ:
//    - Holds the head/iss/tail pointers, the count and the entry storage.
//    - Ports: alloc_n, commit_n, issue_pop, flush.
//  - Top level holds the accept logic, the age arbiter and the perf counter.
// TESTING
//  1. Reset, then dispatch ld {0x85, 0x86, -, -}, st none, rob_head = 5, ready = 1
//     -> lq_count = 2; issue 0x05 then 0x06; mem_req_is_st = 0.
//  2. LQ at 14/16, dispatch 3 loads -> disp_stall = 1 with lq_count unchanged;
//     commit 1 -> still stalls that cycle, accepted the next cycle.
//  3. Load idx 0x7E and store idx 0x01 both pending, rob_head = 0x7C
//     -> store loses; load 0x7E issues first (age 2 vs 5).
//  4. ready held 0 for 3 cycles while new groups arrive
//     -> mem_req_indx stays constant; it advances only when ready = 1.
//  5. Flush with LQ = 5 and SQ = 3 and disp_valid = 1
//     -> disp_stall = 1, mem_req_valid = 0; next cycle both counts = 0.
//  6. rst_n asserted mid-issue -> outputs go to 0 immediately.
//     With LSQ_PERF_CNT_EN: 20 stall cycles -> disp_stall_cnt = 20.

Source files
------------

// File: rtl/lsq_pkg.sv
// Shared types and helpers for the LSQ allocation controller and issue scheduler.
package lsq_pkg;

   localparam int IDX_W = 7;
   localparam int SLOTS = 4;

   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } lsq_slot_t;

   function automatic logic [2:0] popcount4(input logic [SLOTS-1:0] v);
      return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   // Age is the distance from the ROB head, so comparisons stay correct across index wrap.
   function automatic logic age_older(input logic [IDX_W-1:0] a,
                                      input logic [IDX_W-1:0] b,
                                      input logic [IDX_W-1:0] head);
      logic [IDX_W-1:0] da;
      logic [IDX_W-1:0] db;
      da = a - head;
      db = b - head;
      return da < db;
   endfunction

endpackage

// File: rtl/lsq_ring_ctrl.sv
// Circular queue of ROB indices with commit (head), issue (iss) and allocate (tail) pointers.
module lsq_ring_ctrl
   import lsq_pkg::*;
#(
   parameter  int DEPTH = 16,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   input  logic [2:0]                  alloc_n,
   input  logic [SLOTS-1:0][IDX_W-1:0] alloc_idx,
   input  logic [2:0]                  commit_n,
   input  logic                        issue_pop,
   output logic                        cand_valid,
   output logic [IDX_W-1:0]            cand_idx,
   output logic [CW-1:0]               count
);

   logic [PW-1:0]    head_q, head_d;
   logic [PW-1:0]    iss_q, iss_d;
   logic [PW-1:0]    tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    pend_q, pend_d;
   logic [IDX_W-1:0] mem_q [DEPTH];

   // pend_q counts allocated-but-unissued entries; it disambiguates iss == tail on a full queue.
   always_comb begin
      head_d  = head_q;
      iss_d   = iss_q;
      tail_d  = tail_q;
      count_d = count_q;
      pend_d  = pend_q;
      if (flush) begin
         head_d  = '0;
         iss_d   = '0;
         tail_d  = '0;
         count_d = '0;
         pend_d  = '0;
      end else begin
         head_d  = head_q + PW'(commit_n);
         iss_d   = iss_q + PW'(issue_pop);
         tail_d  = tail_q + PW'(alloc_n);
         count_d = count_q + CW'(alloc_n) - CW'(commit_n);
         pend_d  = pend_q + CW'(alloc_n) - CW'(issue_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         iss_q   <= '0;
         tail_q  <= '0;
         count_q <= '0;
         pend_q  <= '0;
      end else begin
         head_q  <= head_d;
         iss_q   <= iss_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         pend_q  <= pend_d;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < SLOTS; k++) begin
         if (!flush && (3'(k) < alloc_n)) begin
            mem_q[tail_q + PW'(k)] <= alloc_idx[k];
         end
      end
   end

   assign cand_valid = (pend_q != '0);
   assign cand_idx   = mem_q[iss_q];
   assign count      = count_q;

   a_commit_le_issued: assert property (@(posedge clk) disable iff (!rst_n)
      !flush |-> (CW'(commit_n) <= (count_q - pend_q)));

endmodule

// File: rtl/lsq_alloc_sched.sv
// LSQ allocation controller and oldest-first memory issue scheduler.
// Optional LSQ_PERF_CNT_EN adds a saturating dispatch-stall cycle counter (disp_stall_cnt).
module lsq_alloc_sched
   import lsq_pkg::*;
#(
   parameter  int LQ_DEPTH = 16,
   parameter  int SQ_DEPTH = 16,
   localparam int LQ_CW    = $clog2(LQ_DEPTH) + 1,
   localparam int SQ_CW    = $clog2(SQ_DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      ld_indx_in,
   input  logic [31:0]      st_indx_in,
   input  logic             disp_valid,
   output logic             disp_stall,
   input  logic [2:0]       ld_cmt_cnt,
   input  logic [2:0]       st_cmt_cnt,
   input  logic [IDX_W-1:0] rob_head,
   input  logic             flush,
   output logic             mem_req_valid,
   output logic             mem_req_is_st,
   output logic [IDX_W-1:0] mem_req_indx,
   input  logic             mem_req_ready,
   output logic [LQ_CW-1:0] lq_count,
   output logic [SQ_CW-1:0] sq_count
`ifdef LSQ_PERF_CNT_EN
   ,
   output logic [15:0]      disp_stall_cnt
`endif
);

   logic [SLOTS-1:0]            ld_v, st_v;
   logic [SLOTS-1:0][IDX_W-1:0] ld_idx, st_idx;
   logic [2:0]                  nld, nst;
   logic [2:0]                  lq_alloc, sq_alloc;
   logic [LQ_CW-1:0]            lq_free;
   logic [SQ_CW-1:0]            sq_free;
   logic                        accept;
   logic                        ld_cand, st_cand;
   logic [IDX_W-1:0]            ld_cand_idx, st_cand_idx;
   logic                        sel_st, req_vld, fire;

   always_comb begin
      lsq_slot_t ls;
      lsq_slot_t ss;
      for (int k = 0; k < SLOTS; k++) begin
         ls        = ld_indx_in[8*k +: 8];
         ss        = st_indx_in[8*k +: 8];
         ld_v[k]   = ls.valid;
         ld_idx[k] = ls.idx;
         st_v[k]   = ss.valid;
         st_idx[k] = ss.idx;
      end
   end

   assign nld = popcount4(ld_v);
   assign nst = popcount4(st_v);

   // Free space is judged on registered counts only; same-cycle commits do not help.
   assign lq_free    = LQ_CW'(LQ_DEPTH) - lq_count;
   assign sq_free    = SQ_CW'(SQ_DEPTH) - sq_count;
   assign accept     = disp_valid && !flush
                       && (lq_free >= LQ_CW'(nld)) && (sq_free >= SQ_CW'(nst));
   assign disp_stall = disp_valid && !accept;
   assign lq_alloc   = accept ? nld : 3'd0;
   assign sq_alloc   = accept ? nst : 3'd0;

   assign sel_st        = st_cand && (!ld_cand || age_older(st_cand_idx, ld_cand_idx, rob_head));
   assign req_vld       = !flush && (ld_cand || st_cand);
   assign fire          = req_vld && mem_req_ready;
   assign mem_req_valid = req_vld;
   assign mem_req_is_st = req_vld && sel_st;
   assign mem_req_indx  = !req_vld ? '0 : (sel_st ? st_cand_idx : ld_cand_idx);

   lsq_ring_ctrl #(.DEPTH(LQ_DEPTH)) u_lq (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .alloc_n    (lq_alloc),
      .alloc_idx  (ld_idx),
      .commit_n   (ld_cmt_cnt),
      .issue_pop  (fire && !sel_st),
      .cand_valid (ld_cand),
      .cand_idx   (ld_cand_idx),
      .count      (lq_count)
   );

   lsq_ring_ctrl #(.DEPTH(SQ_DEPTH)) u_sq (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .alloc_n    (sq_alloc),
      .alloc_idx  (st_idx),
      .commit_n   (st_cmt_cnt),
      .issue_pop  (fire && sel_st),
      .cand_valid (st_cand),
      .cand_idx   (st_cand_idx),
      .count      (sq_count)
   );

`ifdef LSQ_PERF_CNT_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (disp_stall && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign disp_stall_cnt = stall_cnt_q;
`endif

   // Valid bytes must form a contiguous run starting at byte 0.
   a_contig_valid: assert property (@(posedge clk) disable iff (!rst_n)
      disp_valid |-> ((((ld_v + 4'd1) & ld_v) == 4'd0) && (((st_v + 4'd1) & st_v) == 4'd0)));

endmodule

// File: tb/tb_lsq_alloc_sched.sv
// Randomized bench for lsq_alloc_sched against a sequence-number queue model.
module tb_lsq_alloc_sched;

   localparam int DEPTH = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ld_indx_in, st_indx_in;
   logic        disp_valid, disp_stall;
   logic [2:0]  ld_cmt_cnt, st_cmt_cnt;
   logic [6:0]  rob_head;
   logic        flush;
   logic        mem_req_valid, mem_req_is_st, mem_req_ready;
   logic [6:0]  mem_req_indx;
   logic [4:0]  lq_count, sq_count;
`ifdef LSQ_PERF_CNT_EN
   logic [15:0] disp_stall_cnt;
`endif

   always #5 clk = ~clk;

   lsq_alloc_sched #(.LQ_DEPTH(DEPTH), .SQ_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ld_indx_in    (ld_indx_in),
      .st_indx_in    (st_indx_in),
      .disp_valid    (disp_valid),
      .disp_stall    (disp_stall),
      .ld_cmt_cnt    (ld_cmt_cnt),
      .st_cmt_cnt    (st_cmt_cnt),
      .rob_head      (rob_head),
      .flush         (flush),
      .mem_req_valid (mem_req_valid),
      .mem_req_is_st (mem_req_is_st),
      .mem_req_indx  (mem_req_indx),
      .mem_req_ready (mem_req_ready),
      .lq_count      (lq_count),
      .sq_count      (sq_count)
`ifdef LSQ_PERF_CNT_EN
      ,
      .disp_stall_cnt(disp_stall_cnt)
`endif
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Model: each queue holds global sequence numbers of in-flight entries, oldest at front;
   // the first *_iss entries of each queue have been issued.
   int lq_q[$];
   int sq_q[$];
   int lq_iss, sq_iss;
   int next_seq;
   bit grp_pend;
   int grp_nld, grp_nst, grp_base;
   int exp_stall_cnt;
   bit exp_v, exp_sel_st, exp_stall;
   int issued_total;

   function automatic int oldest_seq();
      int m;
      m = grp_pend ? grp_base : next_seq;
      if (lq_q.size() > 0 && lq_q[0] < m) m = lq_q[0];
      if (sq_q.size() > 0 && sq_q[0] < m) m = sq_q[0];
      return m;
   endfunction

   function automatic int min_int(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_clear();
      lq_q.delete();
      sq_q.delete();
      lq_iss   = 0;
      sq_iss   = 0;
      grp_pend = 0;
   endtask

   task automatic drive();
      logic [31:0] lw, sw;
      flush = ($urandom_range(0, 99) < 2);
      if (!grp_pend && ((next_seq + 8 - oldest_seq()) < 120) && ($urandom_range(0, 3) != 0)) begin
         grp_nld  = $urandom_range(0, 4);
         grp_nst  = $urandom_range(0, 4);
         grp_base = next_seq;
         next_seq += grp_nld + grp_nst;
         grp_pend = 1;
      end
      lw = '0;
      sw = '0;
      if (grp_pend) begin
         for (int k = 0; k < 4; k++) begin
            if (k < grp_nld) lw[8*k +: 8] = {1'b1, 7'((grp_base + k) % 128)};
            if (k < grp_nst) sw[8*k +: 8] = {1'b1, 7'((grp_base + grp_nld + k) % 128)};
         end
      end
      disp_valid    = grp_pend;
      ld_indx_in    = lw;
      st_indx_in    = sw;
      rob_head      = 7'(oldest_seq() % 128);
      ld_cmt_cnt    = (flush || $urandom_range(0, 2) != 0) ? 3'd0
                      : 3'($urandom_range(0, min_int(4, lq_iss)));
      st_cmt_cnt    = (flush || $urandom_range(0, 2) != 0) ? 3'd0
                      : 3'($urandom_range(0, min_int(4, sq_iss)));
      mem_req_ready = ($urandom_range(0, 9) < 6);
   endtask

   task automatic check_outputs();
      bit ld_c, st_c;
      int exp_idx;
      ld_c       = lq_iss < lq_q.size();
      st_c       = sq_iss < sq_q.size();
      exp_v      = !flush && (ld_c || st_c);
      exp_sel_st = st_c && (!ld_c || (sq_q[sq_iss] < lq_q[lq_iss]));
      exp_idx    = !exp_v ? 0 : ((exp_sel_st ? sq_q[sq_iss] : lq_q[lq_iss]) % 128);
      exp_stall  = disp_valid && (flush || (DEPTH - lq_q.size() < grp_nld)
                                        || (DEPTH - sq_q.size() < grp_nst));
      chk("lq_count", 32'(lq_count), 32'(lq_q.size()));
      chk("sq_count", 32'(sq_count), 32'(sq_q.size()));
      chk("disp_stall", 32'(disp_stall), 32'(exp_stall));
      chk("mem_req_valid", 32'(mem_req_valid), 32'(exp_v));
      chk("mem_req_is_st", 32'(mem_req_is_st), 32'(exp_v && exp_sel_st));
      chk("mem_req_indx", 32'(mem_req_indx), 32'(exp_idx));
   endtask

   task automatic model_update();
      if (exp_stall) exp_stall_cnt++;
      if (flush) begin
         model_clear();
      end else begin
         if (exp_v && mem_req_ready) begin
            issued_total++;
            if (exp_sel_st) sq_iss++;
            else lq_iss++;
         end
         for (int i = 0; i < int'(ld_cmt_cnt); i++) void'(lq_q.pop_front());
         for (int i = 0; i < int'(st_cmt_cnt); i++) void'(sq_q.pop_front());
         lq_iss -= int'(ld_cmt_cnt);
         sq_iss -= int'(st_cmt_cnt);
         if (disp_valid && !exp_stall) begin
            for (int k = 0; k < grp_nld; k++) lq_q.push_back(grp_base + k);
            for (int k = 0; k < grp_nst; k++) sq_q.push_back(grp_base + grp_nld + k);
            grp_pend = 0;
         end
      end
   endtask

   task automatic run_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         drive();
         #2;
         check_outputs();
         @(posedge clk);
         model_update();
         #1;
      end
   endtask

   task automatic zero_inputs();
      ld_indx_in    = '0;
      st_indx_in    = '0;
      disp_valid    = 1'b0;
      ld_cmt_cnt    = '0;
      st_cmt_cnt    = '0;
      rob_head      = '0;
      flush         = 1'b0;
      mem_req_ready = 1'b0;
   endtask

   initial begin
      int prior_pending;
      rst_n         = 1'b0;
      zero_inputs();
      next_seq      = 0;
      exp_stall_cnt = 0;
      issued_total  = 0;
      model_clear();
      #12;
      chk("rst_lq_count", 32'(lq_count), 32'd0);
      chk("rst_sq_count", 32'(sq_count), 32'd0);
      chk("rst_disp_stall", 32'(disp_stall), 32'd0);
      chk("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("rst_mem_req_is_st", 32'(mem_req_is_st), 32'd0);
      chk("rst_mem_req_indx", 32'(mem_req_indx), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_cycles(2000);

      // Asynchronous reset in the middle of traffic.
      prior_pending = lq_q.size() + sq_q.size();
      flush = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_mem_req_valid", 32'(mem_req_valid), 32'd0);
      chk("midrst_mem_req_indx", 32'(mem_req_indx), 32'd0);
      chk("midrst_lq_count", 32'(lq_count), 32'd0);
      chk("midrst_sq_count", 32'(sq_count), 32'd0);
      if (prior_pending == 0) $display("note: queues were empty at mid-run reset");
      zero_inputs();
      model_clear();
      exp_stall_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      run_cycles(2000);

      chk("issue_activity", 32'(issued_total > 100), 32'd1);
`ifdef LSQ_PERF_CNT_EN
      chk("disp_stall_cnt", 32'(disp_stall_cnt), 32'(exp_stall_cnt));
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
